// File: rtl/adc_capture_multi_if.sv
// Bus between the multi-channel ADC capture controller and its surroundings:
// trigger in, shared ADC control and per-channel SDO, packed averaged results out.
interface adc_capture_multi_if #(
   parameter int NUM_CH    = 2,
   parameter int OUT_WIDTH = 16
);
   logic                        trigger;
   logic [NUM_CH-1:0]           adc_sdo;
   logic                        adc_sck;
   logic                        adc_convert;
   logic                        busy;
   logic                        overrun;
   logic                        data_valid;
   logic [NUM_CH*OUT_WIDTH-1:0] data_value;

   modport master (
      input  trigger,
      input  adc_sdo,
      output adc_sck,
      output adc_convert,
      output busy,
      output overrun,
      output data_valid,
      output data_value
   );

   modport slave (
      output trigger,
      output adc_sdo,
      input  adc_sck,
      input  adc_convert,
      input  busy,
      input  overrun,
      input  data_valid,
      input  data_value
   );
endinterface

// File: rtl/adc_capture_multi.sv
// Multi-channel serial ADC capture: on a trigger edge runs 2^AVG_LOG2 convert/readout
// cycles on NUM_CH ADCs sharing CNV/SCK, averages per channel and strobes one packed result.
module adc_capture_multi #(
   parameter int NUM_CH      = 2,
   parameter int DATA_BITS   = 14,
   parameter int OUT_WIDTH   = 16,
   parameter int CONV_CYCLES = 22,
   parameter int SCK_DIV     = 1,
   parameter int AVG_LOG2    = 0
) (
   input  logic                 clk,
   input  logic                 rstn,
   adc_capture_multi_if.master  bus
);
   localparam int ACC_W   = DATA_BITS + AVG_LOG2;
   localparam int CNT_MAX = (CONV_CYCLES > SCK_DIV) ? CONV_CYCLES : SCK_DIV;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = $clog2(DATA_BITS + 1);
   localparam int IDX_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'((1 << AVG_LOG2) - 1);

   typedef enum logic [2:0] {S_IDLE, S_CONV, S_READ, S_ACC, S_DONE} state_t;

   state_t                      r_state, n_state;
   logic [CNT_W-1:0]            r_cnt, n_cnt;
   logic                        r_half, n_half;
   logic [BIT_W-1:0]            r_bit, n_bit;
   logic [IDX_W-1:0]            r_idx, n_idx;
   logic                        r_trig_d;
   logic                        r_sck, r_convert, r_busy, r_valid, r_overrun;
   logic [DATA_BITS-1:0]        r_shift [NUM_CH];
   logic [ACC_W-1:0]            r_acc   [NUM_CH];
   logic [ACC_W-1:0]            w_sum   [NUM_CH];
   logic [NUM_CH*OUT_WIDTH-1:0] r_data;
   logic                        w_edge, w_start, w_sample;

   // Truncating average, zero-extended to the output lane width.
   function automatic logic [OUT_WIDTH-1:0] avg_trunc(input logic [ACC_W-1:0] s);
      return OUT_WIDTH'(s >> AVG_LOG2);
   endfunction

   assign w_edge   = bus.trigger & ~r_trig_d;
   assign w_start  = (r_state == S_IDLE) && w_edge;
   assign w_sample = (r_state == S_READ) && !r_half && (r_cnt == DIV_LAST);

   always_comb begin
      n_state = r_state;
      n_cnt   = r_cnt;
      n_half  = r_half;
      n_bit   = r_bit;
      n_idx   = r_idx;
      case (r_state)
         S_IDLE: if (w_edge) begin
            n_state = S_CONV;
            n_cnt   = '0;
            n_idx   = '0;
         end
         S_CONV: if (r_cnt == CONV_LAST) begin
            n_state = S_READ;
            n_cnt   = '0;
            n_half  = 1'b0;
            n_bit   = '0;
         end else begin
            n_cnt = r_cnt + 1'b1;
         end
         // r_half=0 is the SCK high phase, r_half=1 the low phase of the current bit
         S_READ: if (r_cnt == DIV_LAST) begin
            n_cnt  = '0;
            n_half = ~r_half;
            if (r_half) begin
               if (r_bit == BIT_LAST) n_state = S_ACC;
               else                   n_bit   = r_bit + 1'b1;
            end
         end else begin
            n_cnt = r_cnt + 1'b1;
         end
         S_ACC: if (r_idx == IDX_LAST) begin
            n_state = S_DONE;
         end else begin
            n_state = S_CONV;
            n_idx   = r_idx + 1'b1;
            n_cnt   = '0;
         end
         S_DONE:  n_state = S_IDLE;
         default: n_state = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so the ADC sees glitch-free SCK/CNV.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_half    <= 1'b0;
         r_bit     <= '0;
         r_idx     <= '0;
         r_trig_d  <= 1'b0;
         r_sck     <= 1'b0;
         r_convert <= 1'b0;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= n_state;
         r_cnt     <= n_cnt;
         r_half    <= n_half;
         r_bit     <= n_bit;
         r_idx     <= n_idx;
         r_trig_d  <= bus.trigger;
         r_sck     <= (n_state == S_READ) && !n_half;
         r_convert <= (n_state == S_CONV);
         r_busy    <= (n_state != S_IDLE);
         r_valid   <= (n_state == S_DONE);
         r_overrun <= w_edge && (r_state != S_IDLE);
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) w_sum[c] = r_acc[c] + ACC_W'(r_shift[c]);
   end

   // Result is loaded on the ACC->DONE edge so it is valid alongside the strobe.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_shift[c] <= '0;
            r_acc[c]   <= '0;
         end
         r_data <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_sample) r_shift[c] <= {r_shift[c][DATA_BITS-2:0], bus.adc_sdo[c]};
            if (w_start)                r_acc[c] <= '0;
            else if (r_state == S_ACC) r_acc[c] <= w_sum[c];
            if (r_state == S_ACC && n_state == S_DONE)
               r_data[c*OUT_WIDTH +: OUT_WIDTH] <= avg_trunc(w_sum[c]);
         end
      end
   end

   assign bus.adc_sck     = r_sck;
   assign bus.adc_convert = r_convert;
   assign bus.busy        = r_busy;
   assign bus.overrun     = r_overrun;
   assign bus.data_valid  = r_valid;
   assign bus.data_value  = r_data;
endmodule
